memory_stage: RTL and testbench

// - Y86-64 pipeline memory stage: owns the M pipeline register (captures the execute-stage e_* outputs),
//   the data memory, and the W pipeline register that feeds write-back.
// - Consumer end of the execute-stage output interface. Produces m_valM/m_status for forwarding and
//   W_* for register-file write-back and the hazard unit.

---
 rtl/y86_pkg.sv | 54 +++++
 rtl/memory_stage_data_memory.sv | 48 ++++
 rtl/memory_stage.sv | 132 +++++++++++++
 tb/tb_memory_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register
// "none" id, and the M/W pipeline register layouts with their bubble values.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [1:0]  status;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_reg_t;

    typedef struct packed {
        logic [1:0]  status;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } w_reg_t;

    localparam m_reg_t M_BUBBLE = '{
        status: STAT_AOK, icode: ICODE_NOP, cnd: 1'b0,
        val_e: 64'd0, val_a: 64'd0, dst_e: RNONE, dst_m: RNONE
    };

    localparam w_reg_t W_BUBBLE = '{
        status: STAT_AOK, icode: ICODE_NOP,
        val_e: 64'd0, val_m: 64'd0, dst_e: RNONE, dst_m: RNONE
    };

endpackage

// File: rtl/memory_stage_data_memory.sv
// Byte-addressed, little-endian data memory with one 64-bit asynchronous read
// port and one 64-bit synchronous write port.
//   clk     : write clock
//   addr    : 64-bit byte address shared by read and write
//   we      : write enable (caller already qualifies it with addr_ok)
//   wdata   : 64-bit store data, byte 0 lands at addr
//   rdata   : 64-bit load data, zero when addr is out of range
//   addr_ok : addr..addr+7 lies entirely inside the array
// Contents are never reset.
module data_memory #(
    parameter int    MEM_BYTES = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic [63:0] addr,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        addr_ok
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem_q [MEM_BYTES];
    logic [AW-1:0] idx;

    // Full 64-bit compare so huge addresses cannot alias into the array.
    assign addr_ok = (addr <= 64'(MEM_BYTES - 8));
    assign idx     = addr[AW-1:0];

    always_comb begin
        rdata = 64'd0;
        if (addr_ok) begin
            for (int i = 0; i < 8; i++) begin
                rdata[8*i +: 8] = mem_q[idx + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[idx + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, data memory access, W register.
//   clk, rst        : clock, synchronous active-high reset
//   e_*             : execute-stage outputs captured into M
//   M_bubble        : load a nop bubble into M
//   W_stall         : hold W
//   M_*             : M register contents
//   m_valM, m_status: combinational load data / status of the M instruction
//   W_*             : W register contents for write-back and hazard logic
module memory_stage
    import y86_pkg::*;
#(
    parameter int    MEM_BYTES = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  e_status,
    input  logic [3:0]  e_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic        M_bubble,
    input  logic        W_stall,
    output logic [1:0]  M_status,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [63:0] m_valM,
    output logic [1:0]  m_status,
    output logic [1:0]  W_status,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    m_reg_t      mreg_q, mreg_d;
    w_reg_t      wreg_q, wreg_d;
    logic        rd_en, wr_en, mem_we, addr_ok;
    logic [63:0] addr, rdata;

    always_comb begin
        mreg_d = M_BUBBLE;
        if (!M_bubble) begin
            mreg_d.status = e_status;
            mreg_d.icode  = e_icode;
            mreg_d.cnd    = e_Cnd;
            mreg_d.val_e  = e_valE;
            mreg_d.val_a  = e_valA;
            mreg_d.dst_e  = e_dstE;
            mreg_d.dst_m  = e_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mreg_q <= M_BUBBLE;
        else     mreg_q <= mreg_d;
    end

    // popq/ret address through the old stack pointer in valA; everything
    // else that touches memory uses the effective address in valE.
    always_comb begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = mreg_q.val_e;
        case (mreg_q.icode)
            ICODE_MRMOVQ: rd_en = 1'b1;
            ICODE_POPQ, ICODE_RET: begin
                rd_en = 1'b1;
                addr  = mreg_q.val_a;
            end
            ICODE_RMMOVQ, ICODE_PUSHQ, ICODE_CALL: wr_en = 1'b1;
            default: ;
        endcase
    end

    assign mem_we = wr_en && addr_ok && (mreg_q.status == STAT_AOK) && !rst;

    data_memory #(
        .MEM_BYTES (MEM_BYTES),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk     (clk),
        .addr    (addr),
        .we      (mem_we),
        .wdata   (mreg_q.val_a),
        .rdata   (rdata),
        .addr_ok (addr_ok)
    );

    assign m_valM   = rd_en ? rdata : 64'd0;
    assign m_status = ((rd_en || wr_en) && !addr_ok) ? STAT_ADR : mreg_q.status;

    always_comb begin
        wreg_d = wreg_q;
        if (!W_stall) begin
            wreg_d.status = m_status;
            wreg_d.icode  = mreg_q.icode;
            wreg_d.val_e  = mreg_q.val_e;
            wreg_d.val_m  = m_valM;
            wreg_d.dst_e  = mreg_q.dst_e;
            wreg_d.dst_m  = mreg_q.dst_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wreg_q <= W_BUBBLE;
        else     wreg_q <= wreg_d;
    end

    assign M_status = mreg_q.status;
    assign M_icode  = mreg_q.icode;
    assign M_Cnd    = mreg_q.cnd;
    assign M_valE   = mreg_q.val_e;
    assign M_valA   = mreg_q.val_a;
    assign M_dstE   = mreg_q.dst_e;
    assign M_dstM   = mreg_q.dst_m;

    assign W_status = wreg_q.status;
    assign W_icode  = wreg_q.icode;
    assign W_valE   = wreg_q.val_e;
    assign W_valM   = wreg_q.val_m;
    assign W_dstE   = wreg_q.dst_e;
    assign W_dstM   = wreg_q.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  e_status = 2'b00;
    logic [3:0]  e_icode = 4'h1;
    logic        e_Cnd = 1'b0;
    logic [63:0] e_valE = 64'd0;
    logic [63:0] e_valA = 64'd0;
    logic [3:0]  e_dstE = 4'hF;
    logic [3:0]  e_dstM = 4'hF;
    logic        M_bubble = 1'b0;
    logic        W_stall = 1'b0;
    logic [1:0]  M_status, m_status, W_status;
    logic [3:0]  M_icode, M_dstE, M_dstM, W_icode, W_dstE, W_dstM;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA, m_valM, W_valE, W_valM;

    memory_stage #(.MEM_BYTES(MEM_BYTES), .INIT_FILE("")) u_dut (
        .clk(clk), .rst(rst),
        .e_status(e_status), .e_icode(e_icode), .e_Cnd(e_Cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .M_bubble(M_bubble), .W_stall(W_stall),
        .M_status(M_status), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .m_valM(m_valM), .m_status(m_status),
        .W_status(W_status), .W_icode(W_icode), .W_valE(W_valE),
        .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: instruction sitting in M, the W record, and memory bytes.
    logic [1:0]  r_mst;  logic [3:0] r_mic;  logic r_mcnd;
    logic [63:0] r_mve, r_mva;  logic [3:0] r_mde, r_mdm;
    logic [1:0]  r_wst;  logic [3:0] r_wic;
    logic [63:0] r_wve, r_wvm;  logic [3:0] r_wde, r_wdm;
    logic [7:0]  mem_m [MEM_BYTES];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What the instruction in M does to memory, straight from the ISA rules.
    task automatic model_access(output logic [63:0] valm, output logic [1:0] st,
                                output logic do_wr, output logic [63:0] a);
        logic is_rd, is_wr, ok;
        is_rd = (r_mic == 4'h5) || (r_mic == 4'hB) || (r_mic == 4'h9);
        is_wr = (r_mic == 4'h4) || (r_mic == 4'hA) || (r_mic == 4'h8);
        a     = ((r_mic == 4'hB) || (r_mic == 4'h9)) ? r_mva : r_mve;
        ok    = a <= 64'(MEM_BYTES - 8);
        valm  = 64'd0;
        if (is_rd && ok)
            for (int k = 0; k < 8; k++) valm = valm | (64'(mem_m[int'(a) + k]) << (8 * k));
        st    = ((is_rd || is_wr) && !ok) ? 2'b10 : r_mst;
        do_wr = is_wr && ok && (r_mst == 2'b00);
    endtask

    task automatic set_e(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
        e_status = st; e_icode = ic; e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
        e_Cnd = 1'($urandom_range(0, 1));
    endtask

    task automatic tick(input logic r, input logic b, input logic s);
        logic [63:0] valm, a;
        logic [1:0]  st;
        logic        do_wr;
        rst = r; M_bubble = b; W_stall = s;
        model_access(valm, st, do_wr, a);
        if (!r && do_wr)
            for (int k = 0; k < 8; k++) mem_m[int'(a) + k] = r_mva[8*k +: 8];
        if (r) begin
            r_wst = 2'b00; r_wic = 4'h1; r_wve = 0; r_wvm = 0; r_wde = 4'hF; r_wdm = 4'hF;
        end else if (!s) begin
            r_wst = st; r_wic = r_mic; r_wve = r_mve; r_wvm = valm; r_wde = r_mde; r_wdm = r_mdm;
        end
        if (r || b) begin
            r_mst = 2'b00; r_mic = 4'h1; r_mcnd = 1'b0; r_mve = 0; r_mva = 0; r_mde = 4'hF; r_mdm = 4'hF;
        end else begin
            r_mst = e_status; r_mic = e_icode; r_mcnd = e_Cnd;
            r_mve = e_valE; r_mva = e_valA; r_mde = e_dstE; r_mdm = e_dstM;
        end
        @(posedge clk);
        #1;
        model_access(valm, st, do_wr, a);
        chk("M_status", 64'(M_status), 64'(r_mst));
        chk("M_icode",  64'(M_icode),  64'(r_mic));
        chk("M_Cnd",    64'(M_Cnd),    64'(r_mcnd));
        chk("M_valE",   M_valE,        r_mve);
        chk("M_valA",   M_valA,        r_mva);
        chk("M_dstE",   64'(M_dstE),   64'(r_mde));
        chk("M_dstM",   64'(M_dstM),   64'(r_mdm));
        chk("m_valM",   m_valM,        valm);
        chk("m_status", 64'(m_status), 64'(st));
        chk("W_status", 64'(W_status), 64'(r_wst));
        chk("W_icode",  64'(W_icode),  64'(r_wic));
        chk("W_valE",   W_valE,        r_wve);
        chk("W_valM",   W_valM,        r_wvm);
        chk("W_dstE",   64'(W_dstE),   64'(r_wde));
        chk("W_dstM",   64'(W_dstM),   64'(r_wdm));
    endtask

    logic [63:0] held_w;

    initial begin
        // reset
        set_e(2'b00, 4'h1, 0, 0, 4'hF, 4'hF);
        tick(1, 0, 0);
        chk("rst_M_icode", 64'(M_icode), 64'h1);
        chk("rst_W_icode", 64'(W_icode), 64'h1);
        chk("rst_M_dstE",  64'(M_dstE),  64'hF);
        chk("rst_W_dstM",  64'(W_dstM),  64'hF);
        chk("rst_status",  64'({M_status, m_status, W_status}), 64'd0);

        // give every memory byte a known value
        for (int w = 0; w < MEM_BYTES / 8; w++) begin
            set_e(2'b00, 4'h4, 64'(w * 8), {$urandom, $urandom}, 4'hF, 4'hF);
            tick(0, 0, 0);
        end

        // store then load
        set_e(2'b00, 4'h4, 64'h40, 64'h1122334455667788, 4'hF, 4'hF); tick(0, 0, 0);
        set_e(2'b00, 4'h5, 64'h40, 64'd0, 4'hF, 4'h3);               tick(0, 0, 0);
        chk("ld_valM", m_valM, 64'h1122334455667788);
        chk("ld_byte", 64'(u_dut.u_mem.mem_q[64]), 64'h88);
        set_e(2'b00, 4'h1, 0, 0, 4'hF, 4'hF);                         tick(0, 0, 0);
        chk("ld_W_dstM", 64'(W_dstM), 64'h3);
        chk("ld_W_valM", W_valM, 64'h1122334455667788);

        // push/pop, call/ret
        set_e(2'b00, 4'hA, 64'h1F8, 64'hAB, 4'h4, 4'hF); tick(0, 0, 0);
        set_e(2'b00, 4'hB, 64'h200, 64'h1F8, 4'h4, 4'h2); tick(0, 0, 0);
        chk("pop_valM", m_valM, 64'hAB);
        set_e(2'b00, 4'h8, 64'h1F0, 64'h13, 4'h4, 4'hF); tick(0, 0, 0);
        set_e(2'b00, 4'h9, 64'h1F8, 64'h1F0, 4'h4, 4'hF); tick(0, 0, 0);
        chk("ret_valM", m_valM, 64'h13);

        // bad addresses
        set_e(2'b00, 4'h5, 64'(MEM_BYTES - 4), 0, 4'hF, 4'h1); tick(0, 0, 0);
        chk("bad_ld_st", 64'(m_status), 64'h2);
        chk("bad_ld_valM", m_valM, 64'd0);
        set_e(2'b00, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD, 4'hF, 4'hF); tick(0, 0, 0);
        chk("bad_ld_W", 64'(W_status), 64'h2);
        chk("bad_st_st", 64'(m_status), 64'h2);
        set_e(2'b00, 4'h5, 64'd0, 0, 4'hF, 4'h1); tick(0, 0, 0);

        // non-AOK store is dropped
        set_e(2'b11, 4'h4, 64'h40, 64'hCAFE, 4'hF, 4'hF); tick(0, 0, 0);
        set_e(2'b00, 4'h5, 64'h40, 0, 4'hF, 4'h3);         tick(0, 0, 0);
        chk("ins_nowrite", m_valM, 64'h1122334455667788);
        chk("ins_W", 64'(W_status), 64'h3);

        // bubble over a valid store
        set_e(2'b00, 4'h4, 64'h40, 64'h5555, 4'hF, 4'hF); tick(0, 1, 0);
        chk("bub_icode", 64'(M_icode), 64'h1);
        set_e(2'b00, 4'h5, 64'h40, 0, 4'hF, 4'h3);         tick(0, 0, 0);
        chk("bub_nowrite", m_valM, 64'h1122334455667788);

        // reset during a store
        set_e(2'b00, 4'h4, 64'h48, 64'h7777, 4'hF, 4'hF); tick(0, 0, 0);
        set_e(2'b00, 4'h4, 64'h48, 64'h7777, 4'hF, 4'hF); tick(1, 0, 0);
        set_e(2'b00, 4'h5, 64'h48, 0, 4'hF, 4'h3);         tick(0, 0, 0);

        // W stall for two cycles
        set_e(2'b00, 4'h6, 64'h99, 0, 4'h5, 4'hF); tick(0, 0, 0);
        held_w = W_valE;
        set_e(2'b00, 4'h6, 64'hA1, 0, 4'h6, 4'hF); tick(0, 0, 1);
        set_e(2'b00, 4'h6, 64'hA2, 0, 4'h7, 4'hF); tick(0, 0, 1);
        chk("stall_W_valE", W_valE, held_w);
        chk("stall_M_valE", M_valE, 64'hA2);
        tick(0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [3:0]  ic;
            logic [63:0] ve, va;
            ic = 4'($urandom_range(0, 11));
            ve = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEM_BYTES - 1));
            va = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEM_BYTES - 1));
            if (ic == 4'h4 || ic == 4'hA || ic == 4'h8) va = {$urandom, $urandom};
            set_e(($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00, ic, ve, va,
                  4'($urandom), 4'($urandom));
            tick($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
